uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   8N1 UART receiver; the receive-side counterpart of the core's uart_tx_o transmitter.
//   Samples a serial line and checks the stop bit. Buffers received bytes in a small FIFO
//   and presents them on a valid/ready interface.
//   Used as a host-side peripheral and as the decoding monitor in core-level benches.
// PARAMETERS
//   CLKS_PER_BIT  868  clk cycles per bit (100 MHz / 115200 baud); must be >= 4
//   FIFO_DEPTH    4    receive FIFO entries; power of 2, >= 2
// PORTS
//   clk          in   1  system clock, single clock domain
//   rst_n        in   1  synchronous active-low reset, sampled on posedge clk
//   rx_i         in   1  asynchronous serial input, idle high
//   rx_data_o    out  8  head-of-FIFO byte; valid only while rx_valid_o=1
//   rx_valid_o   out  1  FIFO not empty
//   rx_ready_i   in   1  consumer pops the head when rx_valid_o & rx_ready_i
//   frame_err_o  out  1  one-cycle pulse: stop bit sampled 0
//   overrun_o    out  1  one-cycle pulse: byte dropped, FIFO full
//   busy_o       out  1  receive FSM not in IDLE
// BEHAVIOUR
//   Reset (rst_n=0 at posedge):
//   - both synchroniser flops go to 1; FSM goes to IDLE; bit counter and bit index go to 0
//   - FIFO is emptied; all outputs are 0 (rx_data_o=8'h00)
//   - Reset mid-frame aborts the frame; the partial byte is discarded
//   Input: 2-flop synchroniser; rxs = 2nd flop. All FSM decisions use rxs only.
//   FSM states: IDLE, START, DATA, STOP, WAIT_HI. bcnt counts 0..CLKS_PER_BIT-1.
//   - IDLE: rxs==0 -> START, bcnt=0.
//   - START: at bcnt==CLKS_PER_BIT/2-1 (mid start bit), sample rxs.
//       rxs==0 -> DATA, bcnt=0, idx=0.
//       rxs==1 -> IDLE (glitch rejected, no flags).
//   - DATA: at bcnt==CLKS_PER_BIT-1, shift rxs into bit idx (LSB first) and reset bcnt.
//       Leave for STOP after idx==7.
//   - STOP: at bcnt==CLKS_PER_BIT-1 (mid stop bit), sample rxs.
//       rxs==1 -> push byte, go to IDLE.
//       rxs==0 -> pulse frame_err_o, drop byte, go to WAIT_HI.
//   - WAIT_HI: stay until rxs==1, then IDLE (break condition produces a single error only).
//   Latency: rx_valid_o rises the cycle after the stop-bit sample edge. The push happens at
//     mid stop bit, so back-to-back frames with no idle gap are received.
//   FIFO: show-ahead; rx_data_o = mem[rd_ptr] combinationally from registered storage.
//   - Occupancy counter is $clog2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
//   - Push while full with a simultaneous pop: accepted, count unchanged.
//   - Push while full without a pop: byte dropped, overrun_o pulses for 1 cycle,
//     FIFO contents unchanged.
//   - Pop while empty: ignored.
//   - Simultaneous push and pop when not full: count unchanged, order preserved.
//   frame_err_o and overrun_o are registered and never both asserted (exclusive causes).
// STRUCTURE
//   - uart_pkg: rx_state_e enum (IDLE, START, DATA, STOP, WAIT_HI), UART_DATA_W=8,
//     default CLKS_PER_BIT constant, shared with the transmitter.
//   - Sub-module uart_rx_fifo (parameter DEPTH, WIDTH): push/pop/full/empty/count.
//     Reusable for the TX side.
//   - uart_rx holds the synchroniser, FSM, bit counter, shift register and error pulses.
// TESTING (bench: CLKS_PER_BIT=16, FIFO_DEPTH=4, 10 ns clk; drive frames bit-exact)
//   1. Send 0x55, rx_ready_i=1 -> rx_valid_o high 1 cycle with rx_data_o=0x55;
//      no error pulses; busy_o falls after the stop sample.
//   2. Pull rx_i low for 5 cycles, then high -> no byte; busy_o returns 0 within 8+2 cycles;
//      no errors.
//   3. Send 0xA5 with stop bit 0, held low 3 bit-times -> exactly one frame_err_o pulse;
//      FIFO empty. Next valid 0x3C is received.
//   4. rx_ready_i=0, send 0x01..0x05 -> overrun_o pulses once (on 0x05).
//      Drain yields 0x01,0x02,0x03,0x04 in order; rx_valid_o then 0.
//   5. Send 0x00 then 0xFF with no idle gap -> both bytes received in order; no errors.
//   6. Assert rst_n=0 for 1 cycle during data bit 3 of 0x81 -> all outputs 0 next cycle.
//      Then a full frame 0xC3 is received correctly.
//   Also: loop core uart_tx_o into rx_i; the received stream matches the program's output.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter.
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small show-ahead FIFO; head word is read combinationally.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_i);
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchroniser, bit-timing FSM, stop check, receive FIFO.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_i,
    output logic [UART_DATA_W-1:0] rx_data_o,
    output logic                   rx_valid_o,
    input  logic                   rx_ready_i,
    output logic                   frame_err_o,
    output logic                   overrun_o,
    output logic                   busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]             sync_q, sync_d;
    rx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       bcnt_q, bcnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   rxs;
    logic                   push;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign sync_d = {sync_q[0], rx_i};
    assign rxs    = sync_q[1];

    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                bcnt_d = '0;
                if (!rxs) begin
                    state_d = START;
                end
            end
            START: begin
                bcnt_d = bcnt_q + CNT_W'(1);
                if (bcnt_q == HALF_LAST) begin
                    bcnt_d  = '0;
                    idx_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                bcnt_d = bcnt_q + CNT_W'(1);
                if (bcnt_q == BIT_LAST) begin
                    bcnt_d         = '0;
                    shift_d[idx_q] = rxs;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                bcnt_d = bcnt_q + CNT_W'(1);
                // Sampling mid stop bit leaves half a bit of slack for the next start.
                if (bcnt_q == BIT_LAST) begin
                    bcnt_d      = '0;
                    push        = rxs;
                    frame_err_d = ~rxs;
                    state_d     = rxs ? IDLE : WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign overrun_d = push & fifo_full & ~rx_ready_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q      <= 2'b11;
            state_q     <= IDLE;
            bcnt_q      <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (shift_q),
        .pop_i   (rx_ready_i),
        .rdata_o (rx_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rx_valid_o  = ~fifo_empty;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus a random stream against a queue model.
module tb_uart_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_i = 1'b1;
    logic       rx_ready_i = 1'b0;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (rx_i),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .rx_ready_i  (rx_ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int exp_fe = 0, exp_ov = 0, got_fe = 0, got_ov = 0;
    int start_cyc = 0, rise_cyc = -1;
    int hi_len = 0, last_hi_len = 0;
    logic busy_at_rise = 1'b1;
    logic prev_valid = 1'b0, prev_fe = 1'b0, prev_ov = 1'b0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Model: a good frame enqueues its byte unless four are already held and
    // nobody is draining; a bad stop bit only counts an error.
    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (!stop) exp_fe++;
        else if (!rx_ready_i && exp_q.size() >= DEPTH) exp_ov++;
        else exp_q.push_back(b);
    endtask

    // Called at posedge+2; frame bits are 0=start, 1..8=data, 9=stop.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input int hold_bits, input int abort_bit);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (i == 0) start_cyc = cyc;
            if (i == 9) model_frame(b, stop);
            rx_i = fr[i];
            for (int c = 0; c < CPB; c++) begin
                if (i == abort_bit && c == CPB / 2) begin
                    rst_n = 1'b0;
                    rx_i  = 1'b1;
                    tick(1);
                    check("reset_mid_frame_outputs",
                          {rx_data_o, rx_valid_o, frame_err_o,
                           overrun_o, busy_o}, 0);
                    rst_n = 1'b1;
                    exp_q.delete();
                    return;
                end
                tick(1);
            end
        end
        if (!stop) begin
            tick((hold_bits - 1) * CPB);
            rx_i = 1'b1;
            tick(CPB);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] want;
        if (rst_n) begin
            if (rx_valid_o && rx_ready_i) begin
                check("pop_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    want = exp_q.pop_front();
                    check("pop_data", rx_data_o, want);
                end
                got_q.push_back(rx_data_o);
            end
            if (rx_valid_o && !prev_valid) begin
                rise_cyc     = cyc;
                busy_at_rise = busy_o;
            end
            if (rx_valid_o) hi_len++;
            else if (prev_valid) begin
                last_hi_len = hi_len;
                hi_len      = 0;
            end
            if (frame_err_o || overrun_o) begin
                check("err_exclusive", frame_err_o & overrun_o, 0);
                if (frame_err_o) begin
                    got_fe++;
                    check("fe_one_cycle", prev_fe, 0);
                end
                if (overrun_o) begin
                    got_ov++;
                    check("ov_one_cycle", prev_ov, 0);
                end
            end
        end
        prev_valid = rx_valid_o;
        prev_fe    = frame_err_o;
        prev_ov    = overrun_o;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fe0, ov0, n;
        logic [7:0] b;
        logic       stop;

        tick(3);
        check("reset_outputs",
              {rx_data_o, rx_valid_o, frame_err_o, overrun_o, busy_o}, 0);
        rst_n = 1'b1;
        tick(5);

        // 1: single byte, exact latency from start edge to valid
        rx_ready_i = 1'b1;
        got_q.delete();
        send_frame(8'h55, 1'b1, 1, -1);
        check("t1_latency", rise_cyc - start_cyc, 155);
        check("t1_busy_at_valid", busy_at_rise, 0);
        tick(4);
        check("t1_valid_width", last_hi_len, 1);
        check("t1_byte", got_q.size() == 1 ? got_q[0] : 8'hxx, 8'h55);
        check("t1_no_fe", got_fe, 0);

        // 2: 5-cycle glitch is rejected
        rx_i = 1'b0;
        tick(5);
        check("t2_busy_during_glitch", busy_o, 1);
        rx_i = 1'b1;
        n = 0;
        while (busy_o && n < 10) begin
            tick(1);
            n++;
        end
        check("t2_busy_cleared", busy_o, 0);
        tick(20);
        check("t2_no_byte", rx_valid_o, 0);
        check("t2_no_err", got_fe + got_ov, 0);

        // 3: bad stop bit with a 3-bit break, then a good frame
        fe0 = got_fe;
        send_frame(8'hA5, 1'b0, 3, -1);
        check("t3_one_fe", got_fe - fe0, 1);
        check("t3_fifo_empty", rx_valid_o, 0);
        got_q.delete();
        send_frame(8'h3C, 1'b1, 1, -1);
        tick(4);
        check("t3_next_byte", got_q.size() == 1 ? got_q[0] : 8'hxx, 8'h3C);

        // 4: overrun on the fifth undrained byte
        rx_ready_i = 1'b0;
        ov0 = got_ov;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1, -1);
        tick(4);
        check("t4_one_overrun", got_ov - ov0, 1);
        check("t4_valid_held", rx_valid_o, 1);
        got_q.delete();
        rx_ready_i = 1'b1;
        tick(8);
        check("t4_drain_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check("t4_drain_order", got_q.size() > i ? got_q[i] : 8'hxx, 8'(i + 1));
        check("t4_valid_low", rx_valid_o, 0);

        // 5: back-to-back frames with no idle gap
        got_q.delete();
        fe0 = got_fe;
        send_frame(8'h00, 1'b1, 1, -1);
        send_frame(8'hFF, 1'b1, 1, -1);
        tick(4);
        check("t5_count", got_q.size(), 2);
        check("t5_first", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'h00);
        check("t5_second", got_q.size() > 1 ? got_q[1] : 8'hxx, 8'hFF);
        check("t5_no_fe", got_fe - fe0, 0);

        // 6: reset during data bit 3, then a clean frame
        send_frame(8'h81, 1'b1, 1, 4);
        tick(40);
        got_q.delete();
        send_frame(8'hC3, 1'b1, 1, -1);
        tick(4);
        check("t6_after_reset", got_q.size() == 1 ? got_q[0] : 8'hxx, 8'hC3);

        // random stream: data, stop errors, stalls and idle gaps
        for (int k = 0; k < 40; k++) begin
            rx_ready_i = ($urandom_range(0, 3) != 0);
            b          = 8'($urandom);
            stop       = ($urandom_range(0, 7) != 0);
            send_frame(b, stop, int'($urandom_range(1, 2)), -1);
            tick(int'($urandom_range(0, 20)));
        end
        rx_ready_i = 1'b1;
        tick(20);
        check("rand_fe_total", got_fe, exp_fe);
        check("rand_ov_total", got_ov, exp_ov);
        check("rand_model_drained", exp_q.size(), 0);
        check("rand_valid_low", rx_valid_o, 0);
        check("rand_idle", busy_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
